// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default operand width
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit full adder used by the serial datapath
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first, one bit per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, acc_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, s, co;
  fa_cell u_fa (.x(a_q[0]), .y(b_q[0]), .ci(c_q), .s(s), .co(co));
  // each new sum bit lands at its own position so sum never sees a partial value
  assign acc_nxt = acc_q | (WIDTH'(s) << cnt_q);
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  // next state: capture operands in IDLE, consume one bit per SHIFT cycle, publish on the last
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        a_d     = a;
        b_d     = sub ? ~b : b;
        c_d     = sub | cin;
        cnt_d   = '0;
        acc_d   = '0;
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = co;
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_nxt;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = acc_nxt;
          cout_d  = co;
          ovf_d   = c_q ^ co;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit and 1-bit serial adder
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin, sub;
  logic [7:0] a, b, sum;
  logic       busy, done, cout, ovf;
  logic       start1, a1, b1, cin1, sub1;
  logic       busy1, done1, sum1, cout1, ovf1;
  logic [7:0] prev_sum;
  int         vec = 0;
  int         err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one 8-bit operation; glitch>0 pulses start with other operands that many cycles into SHIFT
  // and also holds start during the DONE cycle
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tcin, input logic tsub, input logic [7:0] es,
                     input logic ec, input logic eo, input int glitch);
    int cyc;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = ~tcin; sub = ~tsub;
    cyc = 1;
    while (!done && cyc < 20) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_hold"}, sum, prev_sum);
      if (cyc == glitch) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 9);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    prev_sum = es;
    if (glitch > 0) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_one_done"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_keep"}, sum, es);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
    prev_sum = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    op8("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    op8("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op8("addff01c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0);
    op8("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    op8("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    op8("sub0000", 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    op8("glitch", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 3);
    op8("add7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    // reset four cycles into SHIFT abandons the operation
    @(negedge clk);
    a = 8'h55; b = 8'h66; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 8'h00);
    chk("mid_rst_cout", cout, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", done, 1'b0);
    end
    prev_sum = 8'h00;
    op8("add0101", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    // WIDTH=1 instance
    for (int k = 0; k < 2; k++) begin
      int cyc;
      @(negedge clk);
      a1 = (k == 0); b1 = 1'b1; cin1 = 1'b1; sub1 = (k == 1); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = 1'b0; sub1 = ~sub1;
      cyc = 1;
      while (!done1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      chk("w1_latency", cyc, 2);
      chk("w1_sum", sum1, 1'b1);
      chk("w1_cout", cout1, (k == 0));
      chk("w1_ovf", ovf1, (k == 1));
      @(negedge clk);
      chk("w1_idle", busy1, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..64.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-007 b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-008 cin  input  1  carry-in for add mode, captured with the operands.
REQ-009 sub  input  1  mode select, captured with the operands: 0 = A+B+cin, 1 = A-B.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when the result registers update.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry-out; in sub mode 1 = no borrow.
REQ-014 ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The FSM SHALL have three states:
- IDLE -> SHIFT on start=1; captures a, b, cin and sub, and clears the bit counter.
- SHIFT -> DONE after the WIDTH-th bit is processed.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 Each SHIFT cycle SHALL process one bit, LSB first:
- bit = A[i] XOR B'[i] XOR c; carry c updated in a flip-flop.
- B' = ~B in sub mode, else B.
- Initial c = 1 in sub mode, else cin.
REQ-017 If start is accepted at edge k, the result SHALL be registered at edge k+WIDTH, done SHALL be high for the cycle after that edge, and the state SHALL be IDLE after edge k+WIDTH+1.
REQ-018 sum, cout and ovf SHALL update only on the SHIFT->DONE transition and SHALL hold their value until the next completed operation; partial results SHALL never appear on sum.
REQ-019 start SHALL be ignored while busy=1, including in DONE; back-to-back operations therefore start no sooner than the first IDLE cycle.
REQ-020 Operand inputs SHALL be don't-care after capture; changes during SHIFT SHALL NOT affect the result.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide; WIDTH=1 SHALL work with a single SHIFT cycle.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; cout and ovf carry all out-of-range information.

Reset
REQ-023 rst_n low SHALL force, asynchronously: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and all internal shift/carry/counter registers to 0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the first start after release SHALL behave normally.

Structure
REQ-025 A shared package serial_adder_pkg SHALL hold the state encoding constants (IDLE, SHIFT, DONE) and the default WIDTH.
REQ-026 The one-bit add SHALL be a sub-module fa_cell (inputs x, y, ci; outputs s, co), instantiated once and fed from the shift registers.

Verification
REQ-027 WIDTH=8, a=0x5A, b=0x3C, cin=0, sub=0 -> done 9 cycles after the start edge, with sum=0x96, cout=0, ovf=1.
REQ-028 WIDTH=8, a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0; with cin=1 -> sum=0x01, cout=1.
REQ-029 WIDTH=8, a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-030 start pulsed again at 3 cycles into SHIFT with different operands -> ignored; exactly one done pulse, carrying the first result.
REQ-031 rst_n low for 1 cycle at 4 cycles into SHIFT -> all outputs 0, no done pulse; the next operation 0x01+0x01 -> sum=0x02.
REQ-032 WIDTH=1, a=1, b=1, cin=1 -> done 2 cycles after start, with sum=1, cout=1, ovf=0.
